pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that replaces the fixed per-boundary ID/EX, EX/MEM and MEM/WB registers of the RISC-V core.
- Adds a valid/ready handshake, a two-entry skid buffer, stall, flush and bubble (NOP) injection.
- One instance per stage boundary. Control and data payloads are configurable in width.
- Control bits are zeroed whenever the output is not valid, so downstream logic sees a NOP.

Parameters:
- CTRL_W, 16: width of the control payload (WBSel, MemRead, MemWrite, Jump, Branch, RegWrite, ALUOp, ...). Zeroed on bubble.
- DATA_W, 160: width of the data payload (instruction, operands, imm, pc, pc+4, ...). Holds its value on bubble.
- CNT_W, 32: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- up_valid_i  in  1  upstream stage presents an entry.
- up_ready_o  out  1  stage can accept an entry. Registered.
- up_ctrl_i  in  CTRL_W  upstream control payload.
- up_data_i  in  DATA_W  upstream data payload.
- dn_valid_o  out  1  entry available to the downstream stage.
- dn_ready_i  in  1  downstream stage accepts the entry.
- dn_ctrl_o  out  CTRL_W  control payload; all zero when dn_valid_o=0.
- dn_data_o  out  DATA_W  data payload of the head entry.
- stall_i  in  1  hold: no downstream transfer this cycle.
- flush_i  in  1  discard all held entries (branch/jump redirect).
- occ_o  out  2  occupancy, 0..2.
- xfer_cnt_o  out  CNT_W  downstream transfer count (optional feature).
- bubble_cnt_o  out  CNT_W  cycles with dn_valid_o=0 or stall_i=1 (optional feature).

Behaviour:
- Reset values (rst=1 at a clock edge):
  - occ_o=0, dn_valid_o=0, up_ready_o=1.
  - dn_ctrl_o=0, dn_data_o=0.
  - Skid register cleared; counters 0.
- Handshakes:
  - Upstream accept: up_valid_i && up_ready_o.
  - Downstream transfer: dn_valid_o && dn_ready_i && !stall_i.
- State machine (encoded by occupancy):
  - EMPTY (occ 0):
    - accept → FULL. Entry lands in the main register, visible on dn_* the next cycle (1-cycle latency).
  - FULL (occ 1):
    - accept and transfer → stay FULL, main register takes the new entry.
    - accept only → SKID, new entry goes to the skid register.
    - transfer only → EMPTY.
    - neither → hold.
  - SKID (occ 2):
    - up_ready_o=0, so no accept.
    - transfer → FULL; the skid entry moves to the main register next cycle.
- up_ready_o is registered and equals (next occ != 2). Throughput is one entry per cycle with no combinational ready path upstream.
- Ordering is strictly FIFO. The main register is always the oldest entry.
- stall_i:
  - Blocks downstream transfer regardless of dn_ready_i.
  - dn_valid_o still reflects occupancy.
  - Upstream accepts continue until SKID is reached.
- flush_i:
  - Highest priority after rst.
  - Next cycle: occ_o=0, dn_valid_o=0, dn_ctrl_o=0, up_ready_o=1.
  - A simultaneous accept or transfer is discarded; transfer counting still applies in that cycle.
  - dn_data_o is not required to clear.
- Bubble: whenever dn_valid_o=0, dn_ctrl_o is forced to 0 combinationally from the valid bit.
- rst mid-operation: behaves as flush, and also clears dn_data_o and the counters.
- Simultaneous flush_i and stall_i: flush wins.
- Simultaneous up_valid_i with up_ready_o=0: no effect. Upstream must hold its entry.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - xfer_cnt_o increments on each downstream transfer.
  - bubble_cnt_o increments each cycle with (!dn_valid_o || stall_i).
  - Both counters saturate at all-ones and are cleared by rst only, not by flush.
- Undefined: both ports exist and are tied to 0. No counter flops are synthesised.

Decomposition:
- Shared package (defines): pipe_state_e {PS_EMPTY, PS_FULL, PS_SKID}; stage control struct typedefs (id_ex_ctrl_t, ex_mem_ctrl_t, mem_wb_ctrl_t) whose $bits sets CTRL_W at instantiation.
- One sub-module: sat_counter (CNT_W, inc, rst → saturating count), instantiated twice under the macro.

Test Plan:
- Reset: rst=1 for 2 cycles with up_valid_i=1 → occ_o=0, up_ready_o=1, dn_valid_o=0, dn_ctrl_o=0.
- Streaming: dn_ready_i=1 constantly, 8 entries data=0x10..0x17 → outputs 0x10..0x17 on consecutive cycles, 1-cycle latency, up_ready_o never low.
- Skid: dn_ready_i=0, push 0xA1 then 0xA2 → occ_o=2, up_ready_o=0, dn_data_o=0xA1. Release → 0xA1 then 0xA2, no loss or duplication.
- Stall: occ 1 holding ctrl=0x00FF, stall_i=1 with dn_ready_i=1 for 3 cycles → no transfer, dn_ctrl_o=0x00FF held. Release → single transfer.
- Flush: occ 2 with simultaneous push of 0xB3 and flush_i=1 → next cycle occ_o=0, dn_valid_o=0, dn_ctrl_o=0, up_ready_o=1. 0xB3 never appears.
- Stats (macro defined): 5 transfers and 3 idle cycles → xfer_cnt_o=5, bubble_cnt_o=3. With CNT_W=2, forced overflow stays at 3.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared types for the pipeline-stage registers.
// Occupancy-encoded state, per-boundary control bundles, helpers.
package pipe_stage_reg_pkg;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_e;

    localparam logic [1:0] OCC_MAX = 2'd2;

    // ID/EX control bundle, 16 bits.
    typedef struct packed {
        logic [1:0] wb_sel;
        logic       mem_read;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       reg_write;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [3:0] rsvd;
    } id_ex_ctrl_t;

    // EX/MEM control bundle, 8 bits.
    typedef struct packed {
        logic [1:0] wb_sel;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] rsvd;
    } ex_mem_ctrl_t;

    // MEM/WB control bundle, 4 bits.
    typedef struct packed {
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       rsvd;
    } mem_wb_ctrl_t;

    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        return s;
    endfunction

    function automatic logic ready_of(input pipe_state_e s);
        return s != PS_SKID;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat.sv
// sat_counter: synchronous saturating up-counter.
// Ports: clk, rst (sync, high), inc, cnt[CNT_W-1:0]; holds at all-ones.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with 2-entry skid buffer.
// Ports: clk, rst; up_valid_i/up_ready_o/up_ctrl_i/up_data_i upstream;
// dn_valid_o/dn_ready_i/dn_ctrl_o/dn_data_o downstream; stall_i, flush_i;
// occ_o occupancy; xfer_cnt_o/bubble_cnt_o stats (PIPE_STAGE_STATS_EN).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  xfer_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        ready_q;

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    logic accept;
    logic xfer;
    logic ld_main_up;
    logic ld_main_skid;
    logic ld_skid;

    assign dn_valid_o = (state_q != PS_EMPTY);
    assign accept     = up_valid_i && ready_q;
    assign xfer       = dn_valid_o && dn_ready_i && !stall_i;

    always_comb begin
        state_d      = state_q;
        ld_main_up   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush_i) begin
            state_d = PS_EMPTY;
        end else begin
            unique case (1'b1)
                (state_q == PS_EMPTY): begin
                    if (accept) begin
                        ld_main_up = 1'b1;
                        state_d    = PS_FULL;
                    end
                end
                (state_q == PS_FULL): begin
                    if (accept && xfer) begin
                        ld_main_up = 1'b1;
                    end else if (accept) begin
                        ld_skid = 1'b1;
                        state_d = PS_SKID;
                    end else if (xfer) begin
                        state_d = PS_EMPTY;
                    end
                end
                (state_q == PS_SKID): begin
                    // The skid entry is younger; it becomes head.
                    if (xfer) begin
                        ld_main_skid = 1'b1;
                        state_d      = PS_FULL;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            // Registered ready: no combinational path from downstream.
            ready_q <= ready_of(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (ld_main_up) begin
            main_ctrl_q <= up_ctrl_i;
            main_data_q <= up_data_i;
        end else if (ld_main_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (ld_skid) begin
            skid_ctrl_q <= up_ctrl_i;
            skid_data_q <= up_data_i;
        end
    end

    assign up_ready_o = ready_q;
    assign occ_o      = occ_of(state_q);
    // Bubble: control forced to NOP whenever nothing is presented.
    assign dn_ctrl_o  = dn_valid_o ? main_ctrl_q : '0;
    assign dn_data_o  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
    logic bubble;
    assign bubble = !dn_valid_o || stall_i;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_xfer_cnt (
        .clk (clk),
        .rst (rst),
        .inc (xfer),
        .cnt (xfer_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble),
        .cnt (bubble_cnt_o)
    );
`else
    assign xfer_cnt_o   = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Directed skid/stall/flush cases plus constrained-random traffic.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int CW = $bits(id_ex_ctrl_t);
    localparam int DW = 160;
    localparam int NW = 32;

    logic          clk;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [CW-1:0] up_ctrl;
    logic [DW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [CW-1:0] dn_ctrl;
    logic [DW-1:0] dn_data;
    logic          stall;
    logic          flush;
    logic [1:0]    occ;
    logic [NW-1:0] xfer_cnt;
    logic [NW-1:0] bubble_cnt;

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .CNT_W  (NW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .up_valid_i   (up_valid),
        .up_ready_o   (up_ready),
        .up_ctrl_i    (up_ctrl),
        .up_data_i    (up_data),
        .dn_valid_o   (dn_valid),
        .dn_ready_i   (dn_ready),
        .dn_ctrl_o    (dn_ctrl),
        .dn_data_o    (dn_data),
        .stall_i      (stall),
        .flush_i      (flush),
        .occ_o        (occ),
        .xfer_cnt_o   (xfer_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

`ifdef PIPE_STAGE_STATS_EN
    logic       ovf_inc;
    logic [1:0] ovf_cnt;
    sat_counter #(
        .CNT_W (2)
    ) u_ovf (
        .clk (clk),
        .rst (rst),
        .inc (ovf_inc),
        .cnt (ovf_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          sb[$];
    int            n_chk;
    int            n_err;
    int            n_pop;
    logic [NW-1:0] exp_x;
    logic [NW-1:0] exp_b;

    task automatic chk(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Sampled at negedge: inputs settled, decides what the next edge does.
    task automatic monitor();
        logic acc;
        logic xf;
        ent_t e;
        acc = up_valid && up_ready;
        xf  = dn_valid && dn_ready && !stall;
        if (rst) begin
            sb.delete();
            exp_x = '0;
            exp_b = '0;
        end else begin
            if (xf && exp_x != '1) exp_x = exp_x + 1'b1;
            if ((!dn_valid || stall) && exp_b != '1) exp_b = exp_b + 1'b1;
            if (!dn_valid) chk("bubble_ctrl", DW'(dn_ctrl), '0);
            if (flush) begin
                sb.delete();
            end else begin
                if (xf) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", DW'(dn_data), '1);
                    end else begin
                        e = sb.pop_front();
                        n_pop++;
                        chk("dn_ctrl", DW'(dn_ctrl), DW'(e.c));
                        chk("dn_data", dn_data, e.d);
                    end
                end
                if (acc) sb.push_back(ent_t'{c: up_ctrl, d: up_data});
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        chk("occ", DW'(occ), DW'(sb.size()));
        chk("up_ready", DW'(up_ready), DW'(sb.size() != 2));
        chk("dn_valid", DW'(dn_valid), DW'(sb.size() != 0));
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        up_valid = 1'b1;
        up_ctrl  = c;
        up_data  = d;
    endtask

    initial begin
        int p0;
        n_chk    = 0;
        n_err    = 0;
        n_pop    = 0;
        exp_x    = '0;
        exp_b    = '0;
        rst      = 1'b1;
        up_valid = 1'b1;
        up_ctrl  = 16'h1234;
        up_data  = DW'(32'hDEAD);
        dn_ready = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
        ovf_inc  = 1'b0;
`endif

        step();
        step();
        chk("rst_occ", DW'(occ), 0);
        chk("rst_ready", DW'(up_ready), 1);
        chk("rst_valid", DW'(dn_valid), 0);
        chk("rst_ctrl", DW'(dn_ctrl), 0);
        chk("rst_data", dn_data, 0);
        chk("rst_xcnt", DW'(xfer_cnt), 0);
        chk("rst_bcnt", DW'(bubble_cnt), 0);
        rst      = 1'b0;
        up_valid = 1'b0;

        // Streaming with downstream always ready.
        step();
        dn_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(CW'(i + 1), DW'(8'h10 + i));
            step();
            chk("stream_valid", DW'(dn_valid), 1);
            chk("stream_data", dn_data, DW'(8'h10 + i));
            chk("stream_ready", DW'(up_ready), 1);
        end
        up_valid = 1'b0;
        step();
        chk("stream_done", DW'(dn_valid), 0);

        // Skid: fill both entries, then drain in order.
        dn_ready = 1'b0;
        push(16'h00A1, DW'(8'hA1));
        step();
        push(16'h00A2, DW'(8'hA2));
        step();
        up_valid = 1'b0;
        chk("skid_occ", DW'(occ), 2);
        chk("skid_ready", DW'(up_ready), 0);
        chk("skid_head", dn_data, DW'(8'hA1));
        step();
        chk("skid_hold", dn_data, DW'(8'hA1));
        dn_ready = 1'b1;
        step();
        chk("skid_next", dn_data, DW'(8'hA2));
        step();
        chk("skid_empty", DW'(occ), 0);

        // Stall holds a single entry.
        dn_ready = 1'b0;
        push(16'h00FF, DW'(8'hC5));
        step();
        up_valid = 1'b0;
        dn_ready = 1'b1;
        stall    = 1'b1;
        p0       = n_pop;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_occ", DW'(occ), 1);
            chk("stall_ctrl", DW'(dn_ctrl), DW'(16'h00FF));
        end
        stall = 1'b0;
        step();
        chk("stall_pops", DW'(n_pop - p0), 1);
        chk("stall_empty", DW'(occ), 0);

        // Flush from SKID with a push pending.
        dn_ready = 1'b0;
        push(16'h00B1, DW'(8'hB1));
        step();
        push(16'h00B2, DW'(8'hB2));
        step();
        chk("flush_pre", DW'(occ), 2);
        push(16'h00B3, DW'(8'hB3));
        flush = 1'b1;
        step();
        flush    = 1'b0;
        up_valid = 1'b0;
        chk("flush_occ", DW'(occ), 0);
        chk("flush_valid", DW'(dn_valid), 0);
        chk("flush_ctrl", DW'(dn_ctrl), 0);
        chk("flush_ready", DW'(up_ready), 1);
        dn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_gone", DW'(dn_valid), 0);
        end

        // Flush beats a simultaneous stall and accept.
        dn_ready = 1'b0;
        push(16'h00D1, DW'(8'hD1));
        step();
        push(16'h00D2, DW'(8'hD2));
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush    = 1'b0;
        stall    = 1'b0;
        up_valid = 1'b0;
        chk("flush_stall", DW'(occ), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            up_valid = 1'($urandom_range(0, 1));
            up_ctrl  = CW'($urandom());
            up_data  = {$urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom()};
            dn_ready = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            step();
        end

        up_valid = 1'b0;
        dn_ready = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < 10 && dn_valid; i++) step();
        chk("drain", DW'(dn_valid), 0);
        chk("sb_left", DW'(sb.size()), 0);

`ifdef PIPE_STAGE_STATS_EN
        chk("xfer_cnt", DW'(xfer_cnt), DW'(exp_x));
        chk("bubble_cnt", DW'(bubble_cnt), DW'(exp_b));
        ovf_inc = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ovf_inc = 1'b0;
        chk("ovf_sat", DW'(ovf_cnt), 3);
`else
        chk("xfer_cnt_off", DW'(xfer_cnt), 0);
        chk("bubble_cnt_off", DW'(bubble_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
